case_sel_reg: RTL and testbench

Registered, parametrised successor to the two-output case-select decoder. Each `sel` value indexes a run-time-programmable table entry that decides, per output, whether that output takes a constant, passes `d`, passes `~d` or holds its previous value. It sits in the synthesis-regression datapath as a clocked case/default decoder with a one-cycle valid pipeline. Its reset table reproduces the legacy fixed decode: sel 0 gives a=0,b=1; sel 1 gives a=1,b=0; any other sel gives a=d,b=d.

---
 rtl/case_sel_reg.sv | 100 ++++++++++
 tb/tb_case_sel_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/case_sel_reg.sv
// Registered case-select decoder with a run-time programmable per-sel table.
// Each table entry picks CONST, PASS, INV or HOLD independently for a and b.
module case_sel_reg #(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] d,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_addr,
    input  logic [1:0]        cfg_a_mode,
    input  logic [DATA_W-1:0] cfg_a_val,
    input  logic [1:0]        cfg_b_mode,
    input  logic [DATA_W-1:0] cfg_b_val,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              valid_out
);

    localparam int N = 1 << SEL_W;

    localparam logic [1:0] M_CONST = 2'd0;
    localparam logic [1:0] M_PASS  = 2'd1;
    localparam logic [1:0] M_INV   = 2'd2;
    localparam logic [1:0] M_HOLD  = 2'd3;

    logic [1:0]        a_mode_q [N];
    logic [DATA_W-1:0] a_val_q  [N];
    logic [1:0]        b_mode_q [N];
    logic [DATA_W-1:0] b_val_q  [N];

    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    function automatic logic [DATA_W-1:0] resolve(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] val,
        input logic [DATA_W-1:0] din,
        input logic [DATA_W-1:0] cur
    );
        logic [DATA_W-1:0] r;
        r = val;
        case (mode)
            M_CONST: r = val;
            M_PASS:  r = din;
            M_INV:   r = ~din;
            M_HOLD:  r = cur;
            default: r = val;
        endcase
        return r;
    endfunction

    // Lookup reads the pre-edge table, so a same-cycle write only takes effect next cycle.
    always_comb begin
        a_next = resolve(a_mode_q[sel], a_val_q[sel], d, a);
        b_next = resolve(b_mode_q[sel], b_val_q[sel], d, b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            valid_out <= 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i == 0) begin
                    a_mode_q[i] <= M_CONST;
                    a_val_q[i]  <= '0;
                    b_mode_q[i] <= M_CONST;
                    b_val_q[i]  <= '1;
                end else if (i == 1) begin
                    a_mode_q[i] <= M_CONST;
                    a_val_q[i]  <= DATA_W'(1);
                    b_mode_q[i] <= M_CONST;
                    b_val_q[i]  <= '0;
                end else begin
                    a_mode_q[i] <= M_PASS;
                    a_val_q[i]  <= '0;
                    b_mode_q[i] <= M_PASS;
                    b_val_q[i]  <= '0;
                end
            end
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                a <= a_next;
                b <= b_next;
            end
            if (cfg_we) begin
                a_mode_q[cfg_addr] <= cfg_a_mode;
                a_val_q[cfg_addr]  <= cfg_a_val;
                b_mode_q[cfg_addr] <= cfg_b_mode;
                b_val_q[cfg_addr]  <= cfg_b_val;
            end
        end
    end

endmodule

// File: tb/tb_case_sel_reg.sv
// Scoreboard bench for case_sel_reg at SEL_W=3, DATA_W=8.
// Expected {valid_out,a,b} words are queued at drive time and popped after the edge.
module tb_case_sel_reg;

    localparam logic [1:0] M_CONST = 2'd0;
    localparam logic [1:0] M_PASS  = 2'd1;
    localparam logic [1:0] M_INV   = 2'd2;
    localparam logic [1:0] M_HOLD  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_in = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] d = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [1:0] cfg_a_mode = '0;
    logic [7:0] cfg_a_val = '0;
    logic [1:0] cfg_b_mode = '0;
    logic [7:0] cfg_b_val = '0;
    logic [7:0] a;
    logic [7:0] b;
    logic       valid_out;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb[$];
    logic [16:0] got;
    logic [16:0] exp;

    case_sel_reg #(.SEL_W(3), .DATA_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .sel(sel),
        .d(d),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_a_mode(cfg_a_mode),
        .cfg_a_val(cfg_a_val),
        .cfg_b_mode(cfg_b_mode),
        .cfg_b_val(cfg_b_val),
        .a(a),
        .b(b),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] dd,
                         input logic [7:0] ea, input logic [7:0] eb);
        valid_in = v;
        sel      = s;
        d        = dd;
        sb.push_back({v, ea, eb});
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] ad, input logic [1:0] am, input logic [7:0] av,
                       input logic [1:0] bm, input logic [7:0] bv);
        valid_in   = 1'b0;
        cfg_we     = 1'b1;
        cfg_addr   = ad;
        cfg_a_mode = am;
        cfg_a_val  = av;
        cfg_b_mode = bm;
        cfg_b_val  = bv;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({valid_out, a, b} !== 17'h0) begin
            errors++;
            $display("FAIL reset got %h want %h", {valid_out, a, b}, 17'h0);
        end
        rst = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic test_legacy();
        logic [7:0] r;
        drive(1'b1, 3'd0, 8'h00, 8'h00, 8'hFF);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL legacy_sel0 got %h want %h", got, exp); end
        drive(1'b1, 3'd1, 8'h5A, 8'h01, 8'h00);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL legacy_sel1 got %h want %h", got, exp); end
        drive(1'b1, 3'd2, 8'h00, 8'h00, 8'h00);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL legacy_sel2_d0 got %h want %h", got, exp); end
        drive(1'b1, 3'd2, 8'hFF, 8'hFF, 8'hFF);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL legacy_sel2_d1 got %h want %h", got, exp); end
        drive(1'b1, 3'd7, 8'h5C, 8'h5C, 8'h5C);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL sweep_sel7 got %h want %h", got, exp); end
        for (int i = 2; i < 8; i++) begin
            r = 8'($urandom_range(0, 255));
            drive(1'b1, 3'(i), r, r, r);
            got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL sweep_sel%0d got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_modes();
        cfg(3'd3, M_INV, 8'h00, M_CONST, 8'h0A);
        drive(1'b1, 3'd3, 8'h05, 8'hFA, 8'h0A);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mode_inv_const got %h want %h", got, exp); end
        cfg(3'd3, M_HOLD, 8'h00, M_PASS, 8'h00);
        drive(1'b1, 3'd3, 8'h03, 8'hFA, 8'h03);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mode_hold_pass got %h want %h", got, exp); end
        cfg(3'd4, M_PASS, 8'h00, M_HOLD, 8'h00);
        drive(1'b1, 3'd4, 8'h11, 8'h11, 8'h03);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mode_pass_hold got %h want %h", got, exp); end
    endtask

    task automatic test_collision();
        cfg_we     = 1'b1;
        cfg_addr   = 3'd0;
        cfg_a_mode = M_PASS;
        cfg_a_val  = 8'h00;
        cfg_b_mode = M_PASS;
        cfg_b_val  = 8'h00;
        drive(1'b1, 3'd0, 8'h01, 8'h00, 8'hFF);
        cfg_we = 1'b0;
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL collision_old got %h want %h", got, exp); end
        drive(1'b1, 3'd0, 8'h01, 8'h01, 8'h01);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL collision_new got %h want %h", got, exp); end
    endtask

    task automatic test_idle();
        drive(1'b1, 3'd1, 8'h00, 8'h01, 8'h00);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL idle_setup got %h want %h", got, exp); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'(i * 3 + 2), 8'(8'hC3 ^ i), 8'h01, 8'h00);
            got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL idle_hold%0d got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_reset_mid();
        cfg(3'd0, M_INV, 8'h00, M_INV, 8'h00);
        cfg(3'd1, M_INV, 8'h00, M_PASS, 8'h00);
        cfg(3'd2, M_CONST, 8'h33, M_CONST, 8'h44);
        cfg(3'd3, M_HOLD, 8'h00, M_HOLD, 8'h00);
        drive(1'b1, 3'd2, 8'h99, 8'h33, 8'h44);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL prog_sel2 got %h want %h", got, exp); end
        rst = 1'b1;
        valid_in = 1'b1;
        sel = 3'd2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({valid_out, a, b} !== 17'h0) begin
            errors++;
            $display("FAIL reset_mid got %h want %h", {valid_out, a, b}, 17'h0);
        end
        drive(1'b1, 3'd0, 8'hAB, 8'h00, 8'hFF);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL post_rst_sel0 got %h want %h", got, exp); end
        drive(1'b1, 3'd1, 8'hAB, 8'h01, 8'h00);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL post_rst_sel1 got %h want %h", got, exp); end
        drive(1'b1, 3'd2, 8'h77, 8'h77, 8'h77);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL post_rst_sel2 got %h want %h", got, exp); end
        drive(1'b1, 3'd3, 8'h66, 8'h66, 8'h66);
        got = {valid_out, a, b}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL post_rst_sel3 got %h want %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_modes();
        test_collision();
        test_idle();
        test_reset_mid();
        valid_in = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
